// File: rtl/display_pkg.sv
// Shared constants and types for the seven-segment display capture path.
// Glyphs and digit selects are active-low, segment bit0 = a ... bit6 = g.
package display_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  localparam logic [3:0] SEL_DIGIT0 = 4'b0111;
  localparam logic [3:0] SEL_DIGIT1 = 4'b1011;
  localparam logic [3:0] SEL_DIGIT2 = 4'b1101;
  localparam logic [3:0] SEL_DIGIT3 = 4'b1110;
  localparam logic [3:0] SEL_BLANK  = 4'b1111;

  typedef enum logic {ST_SETTLING = 1'b0, ST_HELD = 1'b1} state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] nibble;
  } decode_t;

  // Returns {hit, digit[1:0]}; hit is set only when exactly one select is low.
  function automatic logic [2:0] sel_to_digit(input logic [3:0] sel);
    logic [2:0] res;
    case (sel)
      SEL_DIGIT0: res = 3'b100;
      SEL_DIGIT1: res = 3'b101;
      SEL_DIGIT2: res = 3'b110;
      SEL_DIGIT3: res = 3'b111;
      default:    res = 3'b000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seven_segment_decoder.sv
// Combinational active-low glyph to hex nibble decoder; valid is low for
// any pattern outside the sixteen hex glyphs.
module seven_segment_decoder
  import display_pkg::*;
(
  input  logic [6:0] i_glyph,
  output decode_t    o_decode
);

  always_comb begin
    o_decode = '0;
    o_decode.valid = 1'b1;
    case (i_glyph)
      GLYPH_0: o_decode.nibble = 4'h0;
      GLYPH_1: o_decode.nibble = 4'h1;
      GLYPH_2: o_decode.nibble = 4'h2;
      GLYPH_3: o_decode.nibble = 4'h3;
      GLYPH_4: o_decode.nibble = 4'h4;
      GLYPH_5: o_decode.nibble = 4'h5;
      GLYPH_6: o_decode.nibble = 4'h6;
      GLYPH_7: o_decode.nibble = 4'h7;
      GLYPH_8: o_decode.nibble = 4'h8;
      GLYPH_9: o_decode.nibble = 4'h9;
      GLYPH_A: o_decode.nibble = 4'hA;
      GLYPH_B: o_decode.nibble = 4'hB;
      GLYPH_C: o_decode.nibble = 4'hC;
      GLYPH_D: o_decode.nibble = 4'hD;
      GLYPH_E: o_decode.nibble = 4'hE;
      GLYPH_F: o_decode.nibble = 4'hF;
      default: o_decode.valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/display_capture.sv
// Samples a multiplexed four-digit seven-segment bus, captures each digit once
// it has settled, and publishes the reassembled 16-bit value per full frame.
module display_capture
  import display_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 120000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seven_segment,
  input  logic [3:0]  seven_segment_select,
  output logic [15:0] value,
  output logic        frame_valid,
  output logic        capture_error,
  output logic        stale,
  output state_e      o_dbg_state
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_MAX   = CW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [6:0]  r_seg_s1, r_seg_s2;
  logic [3:0]  r_sel_s1, r_sel_s2;
  logic [CW-1:0] r_cnt;
  state_e      r_state;
  logic [15:0] r_shadow;
  logic [3:0]  r_mask;
  logic [TW-1:0] r_tcnt;
  logic [15:0] r_value;
  logic        r_fv, r_err, r_stale;

  logic        w_unstable, w_capture, w_blank, w_sel_hit;
  logic [1:0]  w_digit;
  logic [2:0]  w_sel_dec;
  decode_t     w_dec;
  logic        w_ok, w_bad, w_complete, w_timeout;

  seven_segment_decoder u_decoder (
    .i_glyph  (r_seg_s2),
    .o_decode (w_dec)
  );

  assign w_unstable = (r_seg_s1 != r_seg_s2) || (r_sel_s1 != r_sel_s2);
  // The capture event is the single cycle the stability count steps to its limit.
  assign w_capture  = (r_state == ST_SETTLING) && !w_unstable && (r_cnt == SETTLE_LAST);
  assign w_sel_dec  = sel_to_digit(r_sel_s2);
  assign w_sel_hit  = w_sel_dec[2];
  assign w_digit    = w_sel_dec[1:0];
  assign w_blank    = (r_sel_s2 == SEL_BLANK);
  assign w_ok       = w_capture && w_sel_hit && w_dec.valid;
  assign w_bad      = w_capture && !w_blank && !(w_sel_hit && w_dec.valid);
  assign w_complete = (r_mask == 4'hF);
  assign w_timeout  = !w_ok && (r_tcnt == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg_s1 <= 7'h7F;
      r_seg_s2 <= 7'h7F;
      r_sel_s1 <= SEL_BLANK;
      r_sel_s2 <= SEL_BLANK;
      r_cnt    <= '0;
      r_state  <= ST_SETTLING;
    end else begin
      r_seg_s1 <= seven_segment;
      r_seg_s2 <= r_seg_s1;
      r_sel_s1 <= seven_segment_select;
      r_sel_s2 <= r_sel_s1;
      if (w_unstable)
        r_cnt <= '0;
      else if (r_cnt != SETTLE_MAX)
        r_cnt <= r_cnt + 1'b1;
      case (r_state)
        ST_SETTLING: if (w_capture)  r_state <= ST_HELD;
        ST_HELD:     if (w_unstable) r_state <= ST_SETTLING;
        default:                     r_state <= ST_SETTLING;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= '0;
      r_mask   <= '0;
      r_tcnt   <= '0;
      r_value  <= '0;
      r_fv     <= 1'b0;
      r_err    <= 1'b0;
      r_stale  <= 1'b1;
    end else begin
      if (w_ok || w_timeout)
        r_tcnt <= '0;
      else
        r_tcnt <= r_tcnt + 1'b1;
      if (w_ok)
        r_shadow[{w_digit, 2'b00} +: 4] <= w_dec.nibble;
      // A completed frame and a timeout both restart assembly from scratch.
      if (w_complete || w_timeout)
        r_mask <= '0;
      else if (w_ok)
        r_mask[w_digit] <= 1'b1;
      r_fv <= w_complete;
      if (w_complete)
        r_value <= r_shadow;
      if (w_complete)
        r_stale <= 1'b0;
      else if (w_timeout)
        r_stale <= 1'b1;
      r_err <= w_bad;
    end
  end

  assign value         = r_value;
  assign frame_valid   = r_fv;
  assign capture_error = r_err;
  assign stale         = r_stale;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_display_capture.sv
// Bench for display_capture: directed vector tables, hand sequences for the
// timeout and reset corners, and random bus traffic against a window-based model.
module tb_display_capture;

  localparam int SETTLE = 4;
  localparam int TMO    = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  sel;
  logic [15:0] value;
  logic        frame_valid, capture_error, stale;
  display_pkg::state_e dbg_state;

  display_capture #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .seven_segment        (seg),
    .seven_segment_select (sel),
    .value                (value),
    .frame_valid          (frame_valid),
    .capture_error        (capture_error),
    .stale                (stale),
    .o_dbg_state          (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  logic [6:0]  glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [11:0] hist [SETTLE+2];   // pin samples, [SETTLE+1] newest; bit 11 marks "no sample"
  logic [3:0]  m_sh [4];
  logic [3:0]  m_mask;
  logic [15:0] m_value;
  logic        m_fv, m_err, m_stale;
  int          m_t;

  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fv_seen, err_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic [3:0] psel, input logic [6:0] pseg);
    logic        cap, complete, ok, bad, to;
    logic [10:0] cp;
    int          zeros, d, nib;
    if (r) begin
      for (int i = 0; i < 4; i++) m_sh[i] = 4'h0;
      m_mask = 4'h0; m_value = 16'h0; m_fv = 1'b0; m_err = 1'b0; m_stale = 1'b1; m_t = 0;
      for (int i = 0; i < SETTLE + 2; i++) hist[i] = 12'h800;
      hist[SETTLE+1] = {1'b0, 4'hF, 7'h7F};
      exp_q.delete();
      return;
    end
    // A capture fires once: when SETTLE+1 identical samples follow a different one.
    cap = (hist[0] != hist[1]);
    for (int i = 1; i <= SETTLE; i++) if (hist[i] != hist[i+1]) cap = 1'b0;
    cp = hist[SETTLE+1][10:0];
    ok = 1'b0; bad = 1'b0; d = 0; nib = -1;
    if (cap && cp[10:7] != 4'hF) begin
      zeros = 0;
      for (int i = 0; i < 4; i++) if (!cp[7+i]) begin zeros++; d = 3 - i; end
      for (int g = 0; g < 16; g++) if (glyph_tab[g] == cp[6:0]) nib = g;
      if (zeros == 1 && nib >= 0) ok = 1'b1; else bad = 1'b1;
    end
    complete = (m_mask == 4'hF);
    if (ok) m_t = 0; else m_t++;
    to = 1'b0;
    if (m_t == TMO) begin to = 1'b1; m_t = 0; end
    m_fv = complete;
    m_err = bad;
    if (complete) begin
      m_value = {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
      exp_q.push_back(m_value);
    end
    if (complete || to) m_mask = 4'h0;
    else if (ok) m_mask[d] = 1'b1;
    if (ok) m_sh[d] = nib[3:0];
    if (complete) m_stale = 1'b0;
    else if (to) m_stale = 1'b1;
    for (int i = 0; i <= SETTLE; i++) hist[i] = hist[i+1];
    hist[SETTLE+1] = {1'b0, psel, pseg};
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic r, input logic [3:0] psel, input logic [6:0] pseg);
    @(negedge clk);
    rst = r; sel = psel; seg = pseg;
    @(posedge clk);
    model_step(r, psel, pseg);
    cyc++;
    #1;
    check("value", 32'(value), 32'(m_value));
    check("frame_valid", 32'(frame_valid), 32'(m_fv));
    check("capture_error", 32'(capture_error), 32'(m_err));
    check("stale", 32'(stale), 32'(m_stale));
    if (frame_valid) begin
      fv_seen++;
      if (exp_q.size() == 0) check("scoreboard unexpected frame", 32'(value), 32'hFFFF_FFFF);
      else check("scoreboard frame", 32'(value), 32'(exp_q.pop_front()));
    end
    if (capture_error) err_seen++;
  endtask

  typedef struct {
    logic [3:0]  sel;
    logic [6:0]  seg;
    int          hold;
    int          exp_fv;
    int          exp_err;
    logic [15:0] exp_value;
    logic        exp_stale;
  } vec_t;

  task automatic apply_vec(input vec_t v);
    fv_seen = 0; err_seen = 0;
    for (int k = 0; k < v.hold; k++) cycle(1'b0, v.sel, v.seg);
    check("vec frame_valid count", 32'(fv_seen), 32'(v.exp_fv));
    check("vec capture_error count", 32'(err_seen), 32'(v.exp_err));
    check("vec value", 32'(value), 32'(v.exp_value));
    check("vec stale", 32'(stale), 32'(v.exp_stale));
  endtask

  // ---------------- test ----------------
  vec_t vec_a[$];
  vec_t vec_b[$];

  initial begin
    int rise;
    logic [3:0] rs;

    vec_a.push_back('{4'b0111, 7'h19, 10, 0, 0, 16'h0000, 1'b1});
    vec_a.push_back('{4'b1011, 7'h30, 10, 0, 0, 16'h0000, 1'b1});
    vec_a.push_back('{4'b1101, 7'h24, 10, 0, 0, 16'h0000, 1'b1});
    vec_a.push_back('{4'b1110, 7'h79, 10, 1, 0, 16'h1234, 1'b0});
    vec_a.push_back('{4'b0111, 7'h19, 10, 0, 0, 16'h1234, 1'b0});
    vec_a.push_back('{4'b1011, 7'h30, 10, 0, 0, 16'h1234, 1'b0});
    vec_a.push_back('{4'b1110, 7'h79, 10, 0, 0, 16'h1234, 1'b0});
    vec_a.push_back('{4'b1101, 7'h24,  3, 0, 0, 16'h1234, 1'b0});
    vec_a.push_back('{4'b1111, 7'h7F, 10, 0, 0, 16'h1234, 1'b0});
    vec_a.push_back('{4'b1101, 7'h24, 10, 1, 0, 16'h1234, 1'b0});
    vec_a.push_back('{4'b1011, 7'h7F, 10, 0, 1, 16'h1234, 1'b0});
    vec_a.push_back('{4'b0011, 7'h40, 10, 0, 1, 16'h1234, 1'b0});

    vec_b.push_back('{4'b1101, 7'h78, 10, 0, 0, 16'h1234, 1'b1});
    vec_b.push_back('{4'b1110, 7'h00, 10, 0, 0, 16'h1234, 1'b1});
    vec_b.push_back('{4'b1111, 7'h7F, 70, 0, 0, 16'h1234, 1'b1});
    vec_b.push_back('{4'b1110, 7'h0E, 10, 0, 0, 16'h1234, 1'b1});
    vec_b.push_back('{4'b1011, 7'h08, 10, 0, 0, 16'h1234, 1'b1});
    vec_b.push_back('{4'b0111, 7'h46, 10, 0, 0, 16'h1234, 1'b1});
    vec_b.push_back('{4'b1101, 7'h40, 10, 1, 0, 16'hF0AC, 1'b0});
    vec_b.push_back('{4'b1110, 7'h0E, 10, 0, 0, 16'hF0AC, 1'b0});
    vec_b.push_back('{4'b1011, 7'h08, 10, 0, 0, 16'hF0AC, 1'b0});
    vec_b.push_back('{4'b0111, 7'h46, 10, 0, 0, 16'hF0AC, 1'b0});
    vec_b.push_back('{4'b1011, 7'h03, 10, 0, 0, 16'hF0AC, 1'b0});
    vec_b.push_back('{4'b1101, 7'h40, 10, 1, 0, 16'hF0BC, 1'b0});

    // reset
    rst = 1'b1; sel = 4'hF; seg = 7'h7F;
    for (int k = 0; k < 3; k++) cycle(1'b1, 4'hF, 7'h7F);
    check("reset value", 32'(value), 32'h0);
    check("reset stale", 32'(stale), 32'h1);
    check("reset frame_valid", 32'(frame_valid), 32'h0);
    check("reset capture_error", 32'(capture_error), 32'h0);
    for (int k = 0; k < 3; k++) cycle(1'b0, 4'hF, 7'h7F);

    foreach (vec_a[i]) apply_vec(vec_a[i]);

    // partial frame then silence: stale must rise 64 cycles after the last capture
    apply_vec('{4'b0111, 7'h12, 10, 0, 0, 16'h1234, 1'b0});
    apply_vec('{4'b1011, 7'h02, 10, 0, 0, 16'h1234, 1'b0});
    rise = 0;
    for (int j = 1; j <= 70; j++) begin
      cycle(1'b0, 4'hF, 7'h7F);
      if (stale && rise == 0) rise = j;
    end
    check("stale rise cycle", 32'(rise), 32'd60);

    foreach (vec_b[i]) apply_vec(vec_b[i]);

    // reset with three digits captured, then only the fourth digit
    apply_vec('{4'b0111, 7'h19, 10, 0, 0, 16'hF0BC, 1'b0});
    apply_vec('{4'b1011, 7'h30, 10, 0, 0, 16'hF0BC, 1'b0});
    apply_vec('{4'b1101, 7'h24, 10, 0, 0, 16'hF0BC, 1'b0});
    cycle(1'b1, 4'b1101, 7'h24);
    cycle(1'b1, 4'b1101, 7'h24);
    apply_vec('{4'b1110, 7'h79, 10, 0, 0, 16'h0000, 1'b1});
    check("post-reset frame_valid", 32'(frame_valid), 32'h0);
    check("post-reset capture_error", 32'(capture_error), 32'h0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      int kind, hold;
      logic [3:0] psel;
      logic [6:0] pseg;
      kind = $urandom_range(0, 9);
      hold = $urandom_range(1, 12);
      psel = 4'hF; pseg = 7'h7F;
      case (kind)
        0, 1, 2, 3, 4, 5: begin
          psel = 4'hF;
          psel[$urandom_range(0, 3)] = 1'b0;
          pseg = glyph_tab[$urandom_range(0, 15)];
        end
        6: begin psel = 4'hF; pseg = 7'h7F; end
        7: begin
          do rs = 4'($urandom_range(0, 15)); while ($countones(rs) > 2);
          psel = rs;
          pseg = glyph_tab[$urandom_range(0, 15)];
        end
        8: begin
          psel = 4'hF;
          psel[$urandom_range(0, 3)] = 1'b0;
          pseg = 7'($urandom_range(0, 127));
        end
        default: begin psel = 4'hF; pseg = 7'h7F; hold = $urandom_range(20, 80); end
      endcase
      if ($urandom_range(0, 49) == 0) begin
        for (int k = 0; k < $urandom_range(1, 2); k++) cycle(1'b1, psel, pseg);
      end
      for (int k = 0; k < hold; k++) cycle(1'b0, psel, pseg);
    end
    for (int k = 0; k < 10; k++) cycle(1'b0, 4'hF, 7'h7F);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_capture.md
# display_capture

Receive side of the multiplexed four-digit seven-segment interface: samples the active-low segment and digit-select lines, waits for each digit to settle, and decodes the glyph back to a hex nibble. Once all four digits are captured it publishes the reassembled 16-bit value. It closes the loop on the display path, for on-board self-check or for sniffing an external display, and runs on the system clock.

## Interface
- `SETTLE_CYCLES`, 4: consecutive stable synchronized samples required before a digit is captured; must be ≥1.
- `TIMEOUT_CYCLES`, 120000: clk cycles without any capture before the partial frame is discarded.
- `clk` input 1: system clock.
- `rst` input 1: reset; synchronous, active-high.
- `seven_segment` input 7: segment lines, active-low, bit0 = a … bit6 = g.
- `seven_segment_select` input 4: digit selects, active-low; `0111` = digit 0 (value[3:0]), `1011` = digit 1, `1101` = digit 2, `1110` = digit 3, `1111` = blank.
- `value` output 16: last complete frame; reset 0.
- `frame_valid` output 1: one-cycle pulse when `value` updates; reset 0.
- `capture_error` output 1: one-cycle pulse on an undecodable settled input; reset 0.
- `stale` output 1: high when no complete frame has arrived since reset or timeout; reset 1.

## Operation
- Both inputs pass through a 2-stage register chain, s1 then s2.
- Stability counter, width clog2(SETTLE_CYCLES+1):
  - Cleared to 0 when s1 ≠ s2 on either bus.
  - Otherwise increments, saturating at SETTLE_CYCLES.
- Capture event: the cycle the counter steps to SETTLE_CYCLES. This happens exactly once per stable window.
- At a capture event, by select value:
  - Blank `1111`: no action, no error.
  - Exactly one select low, and the glyph is in the hex table: nibble written to shadow[digit], mask[digit] set. A later capture of the same digit overwrites it.
  - Exactly one select low, glyph not in the table: `capture_error` pulses, shadow and mask unchanged.
  - Two or more selects low: `capture_error` pulses, shadow and mask unchanged.
- Hex glyph table, active-low, value 0–F: 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E.
- Frame complete (cycle after mask becomes `1111`):
  - `value` ← {shadow3, shadow2, shadow1, shadow0}.
  - `frame_valid` pulses; `stale` ← 0; mask ← 0.
  - Shadow is retained.
- Timeout counter:
  - Reset to 0 on every non-blank successful capture; otherwise increments.
  - On reaching TIMEOUT_CYCLES: mask ← 0, `stale` ← 1, counter ← 0.
  - `value` is held at its last frame.
- State machine, per capture window:
  - SETTLING: counter < SETTLE_CYCLES. Moves to HELD on the capture event.
  - HELD: stays until s1 ≠ s2, then returns to SETTLING.
- Frame assembly order is irrelevant; digits may arrive in any sequence.
- Reset mid-frame: mask, shadow, counters and state are cleared; outputs return to their reset values on the next edge.

## Timing
- Pin change sampled at edge N:
  - Reaches s1 at N.
  - Reaches s2 at N+1.
  - Capture event at edge N+1+SETTLE_CYCLES, provided the pins are held stable throughout.
- Fourth-digit capture at edge C:
  - `value` and `frame_valid` change at edge C+1.
  - `frame_valid` is high for exactly cycle C+1 → C+2.
- `capture_error` is registered and asserts the cycle after the capture event.
- Timeout and frame-complete on the same edge: frame-complete wins, and `stale` ← 0.
- A glitch shorter than SETTLE_CYCLES+1 cycles produces no capture and no error.

## Structure
- Package `display_pkg`:
  - Glyph constants GLYPH_0…GLYPH_F.
  - Select constants SEL_DIGIT0…SEL_DIGIT3 and SEL_BLANK.
  - Digit-count constant (4).
- Sub-module `seven_segment_decoder`: combinational 7-bit glyph → {valid, nibble[3:0]}. Shareable with other display checkers.
- Top-level contents: sync chain, stability counter, SETTLING/HELD FSM, shadow/mask register, timeout counter.

## Test plan
All scenarios run with SETTLE_CYCLES=4 and TIMEOUT_CYCLES=64.
- Drive digits 0..3 with glyphs for 4,3,2,1, each held 10 cycles → one `frame_valid` pulse, `value`=16'h1234, `stale` falls.
- Same frame, but digit 2 is held only 3 cycles, then 10 cycles of blank → no capture and no `frame_valid`; re-drive digit 2 for 10 cycles → `value`=16'h1234.
- Select `1011` with segments 7F (all off) for 10 cycles → one `capture_error` pulse. Select `0011` with a valid glyph → one `capture_error` pulse. `value` unchanged in both cases.
- Capture digits 0 and 1, then blank for 70 cycles → `stale`=1 at cycle 64 after the last capture; a following capture of digits 2,3 alone produces no `frame_valid`.
- Digit order 3,1,0,2 with glyphs F,A,C,0 → `value`=16'hF0AC; digit 1 re-captured as b before completion → `value`=16'hF0BC.
- Assert `rst` after 3 of 4 digits have been captured, then drive only the 4th digit → no `frame_valid`; all outputs at their reset values.
